// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e    : operation codes as presented on op_i
//   state_e : control FSM states
//   to_op / is_div / is_signed / is_acc / is_sub : op-class helpers
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5,
    MSUB  = 3'd6,
    MSUBU = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Map a raw op code onto an operation; anything unrecognised runs as MULTU.
  function automatic op_e to_op(logic [2:0] code);
    op_e op;
    case (code)
      3'd0:    op = MULT;
      3'd1:    op = MULTU;
      3'd2:    op = DIV;
      3'd3:    op = DIVU;
      3'd4:    op = MADD;
      3'd5:    op = MADDU;
      3'd6:    op = MSUB;
      3'd7:    op = MSUBU;
      default: op = MULTU;
    endcase
    return op;
  endfunction

  function automatic logic is_div(op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed(op_e op);
    return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
  endfunction

  function automatic logic is_acc(op_e op);
    return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  function automatic logic is_sub(op_e op);
    return (op == MSUB) || (op == MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one CALC-cycle worth of work, UNROLL bits, purely combinational.
//   div      : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi_in    : partial product high half / partial remainder
//   lo_in    : multiplier bits still to consume / dividend bits shifting into quotient
//   operand  : multiplicand magnitude / divisor magnitude
//   hi_out, lo_out : updated {hi,lo} after UNROLL bits
module muldiv_step #(
  parameter int DATA_W = 32,
  parameter int UNROLL = 1
) (
  input  logic              div,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [DATA_W:0]   t;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // NOTE: combinational logic uses blocking assignments and gives every
  // variable a value up front, so no path through the block leaves a latch.
  always_comb begin
    t  = '0;
    hi = hi_in;
    lo = lo_in;
    for (int i = 0; i < UNROLL; i++) begin
      if (div) begin
        // Shift the next dividend bit into the remainder; subtract if it fits.
        t  = {hi, lo[DATA_W-1]};
        lo = {lo[DATA_W-2:0], 1'b0};
        if (t >= {1'b0, operand}) begin
          t     = t - {1'b0, operand};
          lo[0] = 1'b1;
        end
        // The remainder is now below the divisor, so the top bit is zero.
        hi = t[DATA_W-1:0];
      end else begin
        // Add the multiplicand when the current multiplier bit is set, then
        // shift the whole {carry,hi,lo} right by one.
        t  = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        lo = {t[0], lo[DATA_W-1:1]};
        hi = t[DATA_W:1];
      end
    end
    hi_out = hi;
    lo_out = lo;
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative multiply / divide / multiply-accumulate unit.
//   clk, resetn          : clock, asynchronous active-low reset
//   start_i, op_i        : request and op code, sampled in IDLE
//   src1_i, src2_i       : multiplicand/dividend, multiplier/divisor
//   hl_i                 : current {HI,LO} for MADD/MSUB family
//   annul_i              : abort whatever is in flight
//   result_o             : {HI,LO}; divide gives HI=remainder, LO=quotient
//   ready_o              : one-cycle pulse when result_o is fresh
//   div_zero_o           : set with ready_o for a divide by zero
//   busy_o, stallreq_o   : FSM not idle / stall request to the pipeline
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int UNROLL = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_i,
  input  logic [2:0]          op_i,
  input  logic [DATA_W-1:0]   src1_i,
  input  logic [DATA_W-1:0]   src2_i,
  input  logic [2*DATA_W-1:0] hl_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                div_zero_o,
  output logic                busy_o,
  output logic                stallreq_o
);

  localparam int STEPS = DATA_W / UNROLL;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e              state;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q;        // src1 as captured
  logic [DATA_W-1:0]   b_q;        // src2 as captured, then the step operand
  logic [2*DATA_W-1:0] hl_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                neg_res_q;  // negate product / quotient in FIX
  logic                neg_rem_q;  // negate remainder in FIX
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] result_q;
  logic                div_zero_q;

  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod, prod_s, fix_result;
  logic [DATA_W-1:0]   quo, rem;

  muldiv_step #(.DATA_W(DATA_W), .UNROLL(UNROLL)) u_step (
    .div     (is_div(op_q)),
    .hi_in   (hi_q),
    .lo_in   (lo_q),
    .operand (b_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  always_comb begin
    mag_a = a_q;
    mag_b = b_q;
    if (is_signed(op_q) && a_q[DATA_W-1]) mag_a = -a_q;
    if (is_signed(op_q) && b_q[DATA_W-1]) mag_b = -b_q;

    prod   = {hi_q, lo_q};
    prod_s = neg_res_q ? -prod : prod;
    quo    = neg_res_q ? -lo_q : lo_q;
    rem    = neg_rem_q ? -hi_q : hi_q;

    if (is_div(op_q))      fix_result = {rem, quo};
    else if (is_sub(op_q)) fix_result = hl_q - prod_s;
    else if (is_acc(op_q)) fix_result = hl_q + prod_s;
    else                   fix_result = prod_s;
  end

  // NOTE: every register in this block, datapath included, is reset so the
  // outputs are defined straight out of reset; state uses non-blocking
  // assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      op_q       <= MULTU;
      a_q        <= '0;
      b_q        <= '0;
      hl_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            op_q       <= to_op(op_i);
            a_q        <= src1_i;
            b_q        <= src2_i;
            hl_q       <= hl_i;
            div_zero_q <= 1'b0;
            state      <= PREP;
          end
        end
        PREP: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            neg_res_q <= is_signed(op_q) & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            neg_rem_q <= is_signed(op_q) & a_q[DATA_W-1];
            hi_q      <= '0;
            cnt_q     <= '0;
            if (is_div(op_q) && (b_q == '0)) begin
              result_q   <= {a_q, {DATA_W{1'b1}}};
              div_zero_q <= 1'b1;
              state      <= DONE;
            end else begin
              // Divide walks the dividend through lo; multiply walks the multiplier.
              b_q   <= is_div(op_q) ? mag_b : mag_a;
              lo_q  <= is_div(op_q) ? mag_a : mag_b;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            result_q <= fix_result;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign div_zero_o = div_zero_q;
  assign busy_o     = (state != IDLE);
  // An annul in DONE must suppress the pulse in that very cycle.
  assign ready_o    = (state == DONE) && !annul_i;
  assign stallreq_o = ((state == IDLE) && start_i && !annul_i) ||
                      (((state == PREP) || (state == CALC) || (state == FIX)) && !annul_i);

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench: one UNROLL=1 and one UNROLL=4 instance, directed
// corner cases plus random ops against an arithmetic reference model.
module tb_muldiv_iter_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic           start  [2];
  logic [2:0]     op     [2];
  logic [W-1:0]   s1     [2];
  logic [W-1:0]   s2     [2];
  logic [2*W-1:0] hl     [2];
  logic           annul  [2];
  logic [2*W-1:0] result [2];
  logic           ready  [2];
  logic           dz     [2];
  logic           busy   [2];
  logic           stall  [2];

  logic [2*W-1:0] last_exp [2];

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_iter_unit #(.DATA_W(W), .UNROLL(1)) dut (
    .clk(clk), .resetn(resetn), .start_i(start[0]), .op_i(op[0]),
    .src1_i(s1[0]), .src2_i(s2[0]), .hl_i(hl[0]), .annul_i(annul[0]),
    .result_o(result[0]), .ready_o(ready[0]), .div_zero_o(dz[0]),
    .busy_o(busy[0]), .stallreq_o(stall[0])
  );

  muldiv_iter_unit #(.DATA_W(W), .UNROLL(4)) dut4 (
    .clk(clk), .resetn(resetn), .start_i(start[1]), .op_i(op[1]),
    .src1_i(s1[1]), .src2_i(s2[1]), .hl_i(hl[1]), .annul_i(annul[1]),
    .result_o(result[1]), .ready_o(ready[1]), .div_zero_o(dz[1]),
    .busy_o(busy[1]), .stallreq_o(stall[1])
  );

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definition.
  function automatic logic [2*W-1:0] model(input logic [2:0] opc, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [2*W-1:0] h);
    longint sa, sb;
    logic [2*W-1:0] ua, ub, p;
    logic [W-1:0] q, r;
    logic sgn;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sgn = (opc == MULT) || (opc == DIV) || (opc == MADD) || (opc == MSUB);
    if (opc == DIV || opc == DIVU) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
      return {r, q};
    end
    p = sgn ? 64'(sa * sb) : ua * ub;
    if (opc == MADD || opc == MADDU) return h + p;
    if (opc == MSUB || opc == MSUBU) return h - p;
    return p;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on instance k and check timing, stall behaviour and result.
  task automatic run_op(input int k, input logic [2:0] opc, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] h, input string tag);
    logic [2*W-1:0] exp;
    logic exp_dz, got, stall_ok;
    int lat, exp_lat;
    exp     = model(opc, a, b, h);
    exp_dz  = (opc == DIV || opc == DIVU) && (b == 0);
    exp_lat = exp_dz ? 1 : ((k == 0) ? W + 2 : W / 4 + 2);
    @(negedge clk);
    start[k] = 1'b1; op[k] = opc; s1[k] = a; s2[k] = b; hl[k] = h;
    #1 check({tag, " stall at request"}, 64'(stall[k]), 64'(1));
    @(posedge clk);
    #1;
    // Scramble inputs so a design that fails to capture them is exposed.
    start[k] = 1'b0; s1[k] = $urandom; s2[k] = $urandom; hl[k] = {$urandom, $urandom};
    lat = 0; got = 1'b0; stall_ok = 1'b1;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready[k]) begin
        got = 1'b1;
        break;
      end
      if (!stall[k] || !busy[k]) stall_ok = 1'b0;
    end
    check({tag, " ready seen"}, 64'(got), 64'(1));
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " stall while busy"}, 64'(stall_ok), 64'(1));
    check({tag, " result"}, result[k], exp);
    check({tag, " div_zero"}, 64'(dz[k]), 64'(exp_dz));
    check({tag, " stall in done"}, 64'(stall[k]), 64'(0));
    @(posedge clk);
    #1 check({tag, " ready/busy after"}, {62'b0, ready[k], busy[k]}, 64'(0));
    last_exp[k] = exp;
  endtask

  initial begin
    int seen;
    logic [2:0] ropc;
    logic [W-1:0] ra, rb;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; op[k] = '0; s1[k] = '0; s2[k] = '0; hl[k] = '0; annul[k] = 1'b0;
      last_exp[k] = '0;
    end
    #22;
    for (int k = 0; k < 2; k++) begin
      check("reset outputs", {result[k][61:0], ready[k], dz[k]}, 64'(0));
      check("reset busy/stall", {62'b0, busy[k], stall[k]}, 64'(0));
    end
    @(negedge clk) resetn = 1'b1;

    run_op(0, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, "multu max");
    run_op(0, MULT, -32'sd3, 32'd5, 64'h0, "mult -3x5");
    run_op(0, DIV, -32'sd7, 32'd2, 64'h0, "div -7/2");
    check("div -7/2 literal", result[0], 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(0, DIVU, 32'd7, 32'd2, 64'h0, "divu 7/2");
    run_op(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, "div min/-1");
    check("div min/-1 literal", result[0], 64'h0000_0000_8000_0000);
    run_op(0, DIVU, 32'd5, 32'd0, 64'h0, "divu 5/0");
    check("divu 5/0 literal", result[0], 64'h0000_0005_FFFF_FFFF);
    run_op(0, MADD, 32'd4, 32'd4, 64'h10, "madd");
    run_op(0, MSUBU, 32'd1, 32'd1, 64'h0, "msubu");

    // Annul in IDLE beats a simultaneous start.
    @(negedge clk);
    start[0] = 1'b1; annul[0] = 1'b1; op[0] = MULTU; s1[0] = 32'd9; s2[0] = 32'd9;
    #1 check("annul+start stall", 64'(stall[0]), 64'(0));
    @(posedge clk);
    #1 start[0] = 1'b0; annul[0] = 1'b0;
    check("annul+start busy", 64'(busy[0]), 64'(0));

    // Annul a DIV at CALC cycle 10.
    @(negedge clk);
    start[0] = 1'b1; op[0] = DIV; s1[0] = 32'd1000; s2[0] = 32'd7;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1 check("annul busy before", 64'(busy[0]), 64'(1));
    annul[0] = 1'b1;
    #1 check("annul stall drops", 64'(stall[0]), 64'(0));
    @(posedge clk);
    #1 annul[0] = 1'b0;
    check("annul idle next", 64'(busy[0]), 64'(0));
    check("annul result kept", result[0], last_exp[0]);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (ready[0]) seen++;
    end
    check("annul no ready", 64'(seen), 64'(0));
    run_op(0, MULTU, 32'd2, 32'd3, 64'h0, "multu 2x3");

    // Random ops on both widths.
    for (int i = 0; i < 50; i++) begin
      ropc = 3'($urandom_range(0, 7));
      ra = rnd_val();
      rb = rnd_val();
      run_op(1, ropc, ra, rb, {$urandom, $urandom}, "rand u4");
      if (i < 12) run_op(0, ropc, ra, rb, {$urandom, $urandom}, "rand u1");
    end

    // Reset mid-MULT.
    @(negedge clk);
    start[0] = 1'b1; op[0] = MULT; s1[0] = 32'd123; s2[0] = 32'd456;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("mid-op busy", 64'(busy[0]), 64'(1));
    resetn = 1'b0;
    #1 check("reset mid-op result", result[0], 64'h0);
    check("reset mid-op flags", {60'b0, ready[0], dz[0], busy[0], stall[0]}, 64'(0));
    @(negedge clk) resetn = 1'b1;
    last_exp[0] = '0;
    run_op(0, MULT, 32'd7, -32'sd6, 64'h0, "post-reset mult");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
